// File: rtl/sys_bank_pkg.sv
// Shared types and helpers for the systolic bank controller.
package sys_bank_pkg;

  typedef enum logic [2:0] {
    HOST,
    START,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int RUN_CNT_W = 32;

  // Bank-select width; a single bank still needs a 1-bit select port.
  function automatic int bank_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sys_bank_dpram.sv
// One bank: host side has separate read/write addresses, compute side a single port.
// Both ports read-first; bank ownership keeps the two write ports from colliding.
module sys_bank_dpram #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              a_wr_en,
  input  logic [ADDR_W-1:0] a_wr_addr,
  input  logic [DATA_W-1:0] a_wr_data,
  input  logic              a_rd_en,
  input  logic [ADDR_W-1:0] a_rd_addr,
  output logic [DATA_W-1:0] a_rd_data,
  input  logic              b_wr_en,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wr_data,
  output logic [DATA_W-1:0] b_rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Reads sample the array before this edge's writes land, giving old data.
  always_ff @(posedge clk) begin
    if (a_rd_en) begin
      a_rd_data <= mem[a_rd_addr];
    end
    b_rd_data <= mem[b_addr];
    if (a_wr_en) begin
      mem[a_wr_addr] <= a_wr_data;
    end
    if (b_wr_en) begin
      mem[b_addr] <= b_wr_data;
    end
  end

endmodule

// File: rtl/sys_bank_ctrl.sv
// Bank controller: NUM_BANKS dual-port banks shared between one host port and
// per-bank compute ports, with an ownership FSM handing banks to the array.
module sys_bank_ctrl
  import sys_bank_pkg::*;
#(
  parameter  int NUM_BANKS = 3,
  parameter  int DATA_W    = 32,
  parameter  int DEPTH     = 1024,
  parameter  int DRAIN_CYC = 4,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int BANK_W    = bank_w(NUM_BANKS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          go,
  output logic                          array_start,
  input  logic                          array_done,
  output logic                          finish,
  output logic                          busy,
  output logic [RUN_CNT_W-1:0]          run_cycles,
  input  logic                          host_wr_en,
  input  logic [BANK_W-1:0]             host_wr_bank,
  input  logic [ADDR_W-1:0]             host_wr_addr,
  input  logic [DATA_W-1:0]             host_wr_data,
  input  logic                          host_rd_en,
  input  logic [BANK_W-1:0]             host_rd_bank,
  input  logic [ADDR_W-1:0]             host_rd_addr,
  output logic [DATA_W-1:0]             host_rd_data,
  output logic                          host_rd_valid,
  output logic                          host_err,
  input  logic [NUM_BANKS*ADDR_W-1:0]   cmp_addr,
  input  logic [NUM_BANKS-1:0]          cmp_wr_en,
  input  logic [NUM_BANKS*DATA_W-1:0]   cmp_wr_data,
  output logic [NUM_BANKS*DATA_W-1:0]   cmp_rd_data
);

  localparam int DRN_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC);
  localparam logic [BANK_W:0] BANK_LIM = (BANK_W + 1)'(NUM_BANKS);

  state_t            state;
  logic [DRN_W-1:0]  drain_cnt;
  logic              host_owns;
  logic              cmp_live;
  logic              wr_ok;
  logic              rd_ok;
  logic              access_err;
  logic              rd_ok_q;
  logic [BANK_W-1:0] rd_bank_q;
  logic [DATA_W-1:0] host_q [NUM_BANKS];

  assign host_owns  = (state == HOST);
  assign cmp_live   = (state == RUN) || (state == DRAIN);
  assign wr_ok      = host_wr_en && host_owns && ({1'b0, host_wr_bank} < BANK_LIM);
  assign rd_ok      = host_rd_en && host_owns && ({1'b0, host_rd_bank} < BANK_LIM);
  assign access_err = (host_wr_en && !wr_ok) || (host_rd_en && !rd_ok);

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    sys_bank_dpram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_ram (
      .clk       (clk),
      .a_wr_en   (wr_ok && (host_wr_bank == BANK_W'(i))),
      .a_wr_addr (host_wr_addr),
      .a_wr_data (host_wr_data),
      .a_rd_en   (rd_ok && (host_rd_bank == BANK_W'(i))),
      .a_rd_addr (host_rd_addr),
      .a_rd_data (host_q[i]),
      .b_wr_en   (cmp_live && cmp_wr_en[i]),
      .b_addr    (cmp_addr[i*ADDR_W +: ADDR_W]),
      .b_wr_data (cmp_wr_data[i*DATA_W +: DATA_W]),
      .b_rd_data (cmp_rd_data[i*DATA_W +: DATA_W])
    );
  end

  // Rejected reads still return a valid strobe, but with a zero word.
  always_comb begin
    host_rd_data = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (rd_ok_q && (rd_bank_q == BANK_W'(i))) begin
        host_rd_data = host_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_rd_valid <= 1'b0;
      rd_ok_q       <= 1'b0;
      rd_bank_q     <= '0;
      host_err      <= 1'b0;
    end else begin
      host_rd_valid <= host_rd_en;
      rd_ok_q       <= rd_ok;
      rd_bank_q     <= host_rd_bank;
      if (host_owns && go) begin
        host_err <= 1'b0;
      end
      if (access_err) begin
        host_err <= 1'b1;
      end
    end
  end

  // Ownership FSM; pulses and busy are registered with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HOST;
      drain_cnt   <= '0;
      array_start <= 1'b0;
      finish      <= 1'b0;
      busy        <= 1'b0;
      run_cycles  <= '0;
    end else begin
      array_start <= 1'b0;
      finish      <= 1'b0;
      case (state)
        HOST: begin
          if (go) begin
            state       <= START;
            array_start <= 1'b1;
            busy        <= 1'b1;
            run_cycles  <= '0;
          end
        end
        START: begin
          state <= RUN;
        end
        RUN: begin
          if (run_cycles != '1) begin
            run_cycles <= run_cycles + 1'b1;
          end
          if (array_done) begin
            if (DRAIN_CYC == 0) begin
              state  <= DONE;
              finish <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DRN_W'(DRAIN_CYC - 1);
            end
          end
        end
        DRAIN: begin
          if (run_cycles != '1) begin
            run_cycles <= run_cycles + 1'b1;
          end
          if (drain_cnt == '0) begin
            state  <= DONE;
            finish <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        DONE: begin
          state <= HOST;
          busy  <= 1'b0;
        end
        default: begin
          state <= HOST;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sys_bank_ctrl.md
Name: sys_bank_ctrl

Overview:
- Parametrised bank controller for the systolic datapath. Generalises the fixed A/B-bank wrappers to NUM_BANKS dual-port banks.
- Host side: one shared write port and one shared read port, selected by a bank index.
- Compute side: one port per bank.
- An ownership FSM hands the banks to the array on go, drains late writes, and returns them to the host. It also reports run length.

Parameters:
- NUM_BANKS, 3: number of banks (A, B, C by default); range 2..8.
- DATA_W, 32: word width of each bank.
- DEPTH, 1024: words per bank; must be a power of two.
- DRAIN_CYC, 4: cycles after array_done during which compute writes are still accepted.
- ADDR_W, $clog2(DEPTH): word address width. Derived; not overridable.
- BANK_W, max(1,$clog2(NUM_BANKS)): bank-select width. Derived.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- go  in  1  start request; level, sampled only in HOST
- array_start  out  1  one-cycle start pulse to the array
- array_done  in  1  array finished; sampled only in RUN
- finish  out  1  one-cycle pulse on the return to HOST
- busy  out  1  high whenever state != HOST
- run_cycles  out  32  RUN+DRAIN cycle count of the last run; saturates at 32'hFFFFFFFF
- host_wr_en  in  1  host write strobe
- host_wr_bank  in  BANK_W  host write bank select
- host_wr_addr  in  ADDR_W  host write address
- host_wr_data  in  DATA_W  host write data
- host_rd_en  in  1  host read strobe
- host_rd_bank  in  BANK_W  host read bank select
- host_rd_addr  in  ADDR_W  host read address
- host_rd_data  out  DATA_W  host read data
- host_rd_valid  out  1  host read data valid
- host_err  out  1  sticky access error
- cmp_addr  in  NUM_BANKS*ADDR_W  per-bank compute address; bank i uses slice i
- cmp_wr_en  in  NUM_BANKS  per-bank compute write enable
- cmp_wr_data  in  NUM_BANKS*DATA_W  per-bank compute write data
- cmp_rd_data  out  NUM_BANKS*DATA_W  per-bank compute read data

Behaviour:
- Reset values: all outputs 0; state HOST. Bank contents are not cleared by reset.
- State HOST:
  - Host owns all banks.
  - go=1 moves to START and clears host_err and run_cycles.
- State START (exactly 1 cycle):
  - array_start=1.
  - Next state RUN.
- State RUN:
  - Compute ports are live.
  - run_cycles increments every cycle.
  - array_done=1 moves to DRAIN and loads the drain counter with DRAIN_CYC-1.
  - DRAIN_CYC=0 goes straight to DONE.
- State DRAIN:
  - Compute writes are still accepted; run_cycles keeps counting.
  - When the counter reaches 0, move to DONE.
- State DONE (1 cycle):
  - finish=1.
  - Next state HOST.
- Compute writes:
  - Honoured only in RUN and DRAIN; ignored otherwise.
  - Bank i write address and data come from slice i.
- Compute reads:
  - Synchronous, 1-cycle latency, in every state.
  - Data is undefined outside RUN/DRAIN.
- Host writes:
  - Accepted only in HOST and with host_wr_bank < NUM_BANKS.
  - Otherwise the write is dropped and host_err is set on the next edge.
- Host reads:
  - host_rd_valid follows host_rd_en by exactly 1 cycle in every state.
  - host_rd_data is the bank word when the read was issued in HOST with a valid bank.
  - Otherwise host_rd_data is 0 and host_err is set.
- Bank port collision:
  - Port A is the host port; port B is the compute port.
  - Ownership makes simultaneous host and compute writes to the same bank impossible.
  - Same-address host read plus write in one cycle returns old data (read-first).
- go handling:
  - go held high across DONE→HOST starts a new run the cycle after finish. This is intentional back-to-back operation.
  - go in any state other than HOST is ignored.
- array_done in START is ignored.
- Asynchronous reset mid-run:
  - Returns to HOST immediately with all outputs 0.
  - No finish pulse is issued.
  - Partially written banks keep their contents.
- run_cycles holds its value from DONE until the next accepted go.

Decomposition:
- Package sys_bank_pkg holds:
  - state enum {HOST, START, RUN, DRAIN, DONE}, 3 bits.
  - Constant RUN_CNT_W = 32.
  - Function bank_w(n) returning max(1,$clog2(n)).
- One sub-module, sys_bank_dpram: true dual-port read-first RAM with DATA_W/DEPTH parameters, instantiated NUM_BANKS times in a generate loop.
- The FSM, error logic and counters stay in the top.

Test Plan:
- Load and readback: host writes 0xA5A5_0000+i to bank 0, addr i, for i=0..7, then reads back → host_rd_valid 1 cycle after each read; data matches; host_err=0.
- Full run: go=1 for 1 cycle; array_done after 10 RUN cycles; DRAIN_CYC=4 → array_start exactly 1 cycle; busy for 1+10+4+1 cycles; finish single pulse; run_cycles=14.
- Late write: compute writes bank 2, addr 5, data 0xDEAD_BEEF during the 2nd DRAIN cycle → host read after finish returns 0xDEADBEEF.
- Illegal accesses:
  - Host write during RUN → write dropped; host_err=1.
  - Host read during RUN → data 0; valid asserted.
  - host_wr_bank=3 with NUM_BANKS=3 → host_err=1.
  - A subsequent go → host_err cleared.
- Reset mid-run: assert reset in the 3rd RUN cycle → busy/finish/array_start=0 immediately; data written before reset is still readable afterwards.
- Back-to-back: go held high through DONE → second array_start 2 cycles after the first finish; run_cycles restarts from 0.
